// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB chunk first.
// Latency: done pulses in the cycle after the N-th edge following accept (N = WIDTH/CHUNK).
// Backpressure: start is honoured only while ready=1; requests during CALC/DONE are dropped.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] KLAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;     // operands, shifted right one chunk per CALC edge
  logic             carry_q;      // carry between chunks
  logic [CW-1:0]    k_q;          // index of the chunk being added
  logic [CHUNK:0]   csum;         // current chunk sum including carry out
  logic             msb_cin;      // carry into the chunk MSB (used on the final chunk)
  logic             last;
  logic [WIDTH-1:0] res;          // assembled result including the current chunk

  // The live chunk always sits in the low bits because the operands shift down
  assign csum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
  assign last    = (k_q == KLAST);

  generate
    if (N > 1) begin : g_multi
      logic [WIDTH-CHUNK-1:0] part_q;
      // Finished chunks enter at the top and shift down, so chunk 0 ends up in the LSBs
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          part_q <= '0;
        else if (state == CALC)
          part_q <= res[WIDTH-1:CHUNK];
      end
      assign res = {csum[CHUNK-1:0], part_q};
    end else begin : g_single
      assign res = csum[CHUNK-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start)
          state_nxt = CALC;
      end
      CALC: begin
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk stepping and result load on the final chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= x;
            b_q     <= sub ? ~y : y;
            carry_q <= sub | cin;   // subtract is x + ~y + 1
            k_q     <= '0;
          end
        end
        CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= csum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last) begin
            sum  <= res;
            cout <= csum[CHUNK];
            ovf  <= msb_cin ^ csum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: WIDTH=16 at CHUNK=4/1/16 sharing stimulus, plus a 4/4 instance.
// Expected results are queued at issue time; per-instance monitors compare on done.
// Stimulus waits for all shared instances to be ready before each request.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  x1 = '0, y1 = '0;

  logic        rd0, d0, c0, v0;  logic [15:0] s0;
  logic        rd1, d1, c1, v1;  logic [3:0]  s1;
  logic        rd2, d2, c2, v2;  logic [15:0] s2;
  logic        rd3, d3, c3, v3;  logic [15:0] s3;

  int checks   = 0;
  int failures = 0;

  // Expected {cout, ovf, sum}
  logic [17:0] q0[$], q1[$], q2[$], q3[$];

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
    .ready(rd0), .done(d0), .sum(s0), .cout(c0), .ovf(v0));
  seq_addsub #(.WIDTH(4), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .x(x1), .y(y1), .cin(cin1),
    .ready(rd1), .done(d1), .sum(s1), .cout(c1), .ovf(v1));
  seq_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
    .ready(rd2), .done(d2), .sum(s2), .cout(c2), .ovf(v2));
  seq_addsub #(.WIDTH(16), .CHUNK(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
    .ready(rd3), .done(d3), .sum(s3), .cout(c3), .ovf(v3));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [17:0] got, logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  // Reference: plain 17-bit addition, signed overflow from operand/result signs
  function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic s, logic c);
    logic [15:0] bb;
    logic        ci;
    logic [16:0] t;
    logic        ov;
    bb = s ? ~b : b;
    ci = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, bb} + {16'h0, ci};
    ov = (a[15] == bb[15]) && (t[15] != a[15]);
    return {t[16], ov, t[15:0]};
  endfunction

  task automatic spurious(string nm);
    checks++;
    failures++;
    $display("FAIL %s done with empty queue", nm);
  endtask

  // Monitors: one per instance
  always @(negedge clk) if (!rst && d0) begin
    if (q0.size() == 0) spurious("u0_spurious_done");
    else chk("u0_result", {c0, v0, s0}, q0.pop_front());
  end
  always @(negedge clk) if (!rst && d1) begin
    if (q1.size() == 0) spurious("u1_spurious_done");
    else chk("u1_result", {c1, v1, 12'h0, s1}, q1.pop_front());
  end
  always @(negedge clk) if (!rst && d2) begin
    if (q2.size() == 0) spurious("u2_spurious_done");
    else chk("u2_result", {c2, v2, s2}, q2.pop_front());
  end
  always @(negedge clk) if (!rst && d3) begin
    if (q3.size() == 0) spurious("u3_spurious_done");
    else chk("u3_result", {c3, v3, s3}, q3.pop_front());
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(rd0 && rd2 && rd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout rd0=%b rd2=%b rd3=%b", rd0, rd2, rd3);
    end
  endtask

  // Issue one request to the shared instances; main=0 queues only for u3
  // (used when the slower instances are reset before finishing).
  task automatic issue(input logic [15:0] xx, input logic [15:0] yy, input logic s,
                       input logic c, input logic [17:0] e, input bit main);
    wait_ready();
    x = xx; y = yy; sub = s; cin = c; start = 1'b1;
    if (main) begin
      q0.push_back(e);
      q2.push_back(e);
    end
    q3.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic issue1(input logic [3:0] xx, input logic [3:0] yy, input logic s,
                        input logic c, input logic [17:0] e);
    int lat;
    lat = 0;
    while (!rd1 && lat < 50) begin @(negedge clk); lat++; end
    x1 = xx; y1 = yy; sub1 = s; cin1 = c; start1 = 1'b1;
    q1.push_back(e);
    @(posedge clk);
    #1;
    start1 = 1'b0; x1 = 4'($urandom); y1 = 4'($urandom); cin1 = 1'($urandom);
    lat = 0;
    while (!d1 && lat < 50) begin @(negedge clk); lat++; end
    chk("u1_latency", 18'(lat), 18'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] rx, ry;
    logic        rs, rc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 18'(rd0), 18'h1);
    chk("rst_done",  18'(d0),  18'h0);
    chk("rst_outs",  {c0, v0, s0}, 18'h0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Add, with latency and handshake timing
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b1);
    lat = 0;
    while (!d0 && lat < 50) begin @(negedge clk); lat++; end
    chk("add_latency", 18'(lat), 18'd5);
    chk("ready_low_in_done", 18'(rd0), 18'h0);
    @(negedge clk);
    chk("ready_after_done", 18'(rd0), 18'h1);

    // Carry across every chunk; previous sum must hold during CALC
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("sum_hold", 18'(s0), 18'h5555);

    // Signed overflow, subtract modes
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, 1'b1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF}, 1'b1);

    // start during the 2nd CALC cycle is ignored
    issue(16'h00F0, 16'h0F00, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0FF0}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x = 16'hAAAA; y = 16'h5555; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;

    // Reset during CALC aborts; only the single-chunk instance finishes first
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333}, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 18'(rd0), 18'h1);
    chk("abort_done",  18'(d0),  18'h0);
    chk("abort_outs",  {c0, v0, s0}, 18'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(16'h0101, 16'h0202, 1'b0, 1'b1, {1'b0, 1'b0, 16'h0304}, 1'b1);

    // Single-chunk 4-bit instance
    @(negedge clk);
    issue1(4'h9, 4'h8, 1'b0, 1'b1, {1'b1, 1'b1, 16'h0002});
    issue1(4'h7, 4'h1, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0008});
    issue1(4'h3, 4'h5, 1'b1, 1'b1, {1'b0, 1'b0, 16'h000E});

    // Random operands against the reference model
    for (int i = 0; i < 150; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      if (i < 4) begin
        rx = 16'hFFFF;
        ry = (i[0]) ? 16'h0000 : 16'hFFFF;
      end
      issue(rx, ry, rs, rc, model(rx, ry, rs, rc), 1'b1);
    end

    repeat (40) @(negedge clk);
    chk("q0_drained", 18'(q0.size()), 18'h0);
    chk("q1_drained", 18'(q1.size()), 18'h0);
    chk("q2_drained", 18'(q2.size()), 18'h0);
    chk("q3_drained", 18'(q3.size()), 18'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
